sort_unloader: RTL and testbench
================================

Name: sort_unloader

Overview:
Readout end of the sorting register chain. On a start pulse it snapshots the parallel sorted contents of the chain. It then streams the valid entries out one per transfer over a valid/ready interface, in ascending or descending order. It sits between the sort_reg array and the downstream consumer (UART/display/checker), so the chain can be refilled while results drain.

Parameters:
DATA_W, 8, width of one sorted entry
DEPTH, 8, number of entries in the sort chain
CNT_W, $clog2(DEPTH+1) (4 at defaults), width of count input, derived, not overridden

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  begin unload; sampled only in IDLE
sorted_in  in  DEPTH*DATA_W  chain contents; entry i at [i*DATA_W +: DATA_W]; entry 0 smallest
count  in  CNT_W  number of valid entries (entries 0..count-1); sampled with start
descending  in  1  1 = emit largest first; sampled with start
out_valid  out  1  out_data holds a valid entry
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  DATA_W  current entry
out_last  out  1  current entry is the final one of the unload
busy  out  1  unload in progress (STREAM or DONE)
done  out  1  one-cycle pulse after final transfer (or for an empty unload)

Behaviour:
- Reset (rst=0, async): state IDLE; out_valid=0, out_data=0, out_last=0, busy=0, done=0; snapshot, index, remaining cleared. Reset mid-stream aborts immediately; no done pulse.
- FSM states: IDLE, STREAM, DONE.
- IDLE, start=1 at edge n:
  - Capture sorted_in into the snapshot register.
  - cnt = min(count, DEPTH); values above DEPTH clamp to DEPTH.
  - Latch descending.
  - cnt=0: go to DONE; no out_valid ever asserted.
  - cnt>0: go to STREAM; index = descending ? cnt-1 : 0; remaining = cnt.
- STREAM:
  - out_valid=1, busy=1.
  - out_data = snapshot[index]; out_last = (remaining==1).
  - First out_valid is cycle n+1 (one-cycle latency from start).
- Transfer = out_valid & out_ready at a rising edge.
  - On transfer: index +1 (ascending) or -1 (descending); remaining -1.
  - Transfer with out_last=1: go to DONE.
  - One transfer per cycle max; continuous ready yields back-to-back entries.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable, and out_valid stays high (no retraction).
- DONE: exactly one cycle; done=1, busy=1, out_valid=0, out_last=0; then IDLE. The cycle after DONE is IDLE with busy=0, done=0.
- start while busy: ignored. sorted_in, count and descending changes during an unload: no effect (snapshot isolation).
- out_ready while out_valid=0: ignored.
- Index never wraps. Descending never goes below 0 and ascending never exceeds cnt-1, because remaining ends the stream first.
- Equal entries are emitted in index order (duplicates preserved).
- Total cycles start→done (ready held high) = cnt+1 after the start edge; done is asserted in cycle n+cnt+1.

Test Plan:
- Ascending, DEPTH=8, sorted_in entries {01,04,05,0A,0B,11,55,AA}, count=8, ready=1 → out_data 01,04,05,0A,0B,11,55,AA on consecutive cycles from n+1; out_last only with AA; done pulse at n+9; busy low at n+10.
- Descending, count=3, entries 0..2 = {04,05,AA} → AA,05,04; out_last with 04; entries 3..7 never appear.
- Backpressure: ascending, count=4, ready toggles 1,0,0,1,0,1,1 → every entry held stable while ready=0; exactly 4 transfers; no duplicates, no drops; done one cycle after final transfer.
- Snapshot isolation and re-start: change sorted_in, count and descending mid-stream and pulse start at the same time → output stream unchanged. A start in the cycle right after done begins a new unload with the new values.
- count=0 → out_valid never asserted; done pulse at n+1. count=12 (>DEPTH) → clamped to 8 entries.
- Reset abort: assert rst=0 after the 2nd transfer → out_valid, busy and done go 0 asynchronously. After release, the block is in IDLE and a new start streams from the first entry again.

Source files
------------

// File: rtl/sort_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : sort_unloader
//  Description : Readout end of the sorting register chain. A start pulse
//                snapshots the parallel chain contents, then the valid
//                entries are streamed one per transfer over valid/ready,
//                smallest-first or largest-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_unloader #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DEPTH*DATA_W-1:0] sorted_in,
  input  logic [CNT_W-1:0]        count,
  input  logic                    descending,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  // Index width: enough to address every snapshot slot (at least one bit).
  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Unload sequencer states.
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_stream = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  // Count value that every larger request is clamped down to.
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one_cnt   = CNT_W'(1);

  logic [1:0]         r_state;
  logic [DATA_W-1:0]  r_snap [DEPTH];
  logic [c_idx_w-1:0] r_idx;
  logic [CNT_W-1:0]   r_rem;
  logic               r_desc;

  logic               w_idle;
  logic               w_stream;
  logic               w_launch;
  logic               w_xfer;
  logic               w_final_xfer;
  logic [CNT_W-1:0]   w_cnt;
  logic [c_idx_w-1:0] w_first_idx;
  logic [c_idx_w-1:0] w_next_idx;

  // Decode state, clamp the requested count and work out the walk order.
  always_comb begin
    w_idle       = (r_state == c_st_idle);
    w_stream     = (r_state == c_st_stream);
    w_launch     = w_idle && start;
    w_xfer       = w_stream && out_ready;
    w_final_xfer = w_xfer && (r_rem == c_one_cnt);
    w_cnt        = (count > c_depth_cnt) ? c_depth_cnt : count;
    // For an empty unload the first index is never used, so the wrap of
    // cnt-1 at cnt=0 is harmless.
    w_first_idx  = descending ? c_idx_w'(w_cnt - c_one_cnt) : '0;
    w_next_idx   = r_desc ? (r_idx - 1'b1) : (r_idx + 1'b1);
  end

  // Snapshot the chain on launch so the chain can refill while we drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_snap[i] <= '0;
      end
    end else if (w_launch) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_snap[i] <= sorted_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer: launch, step the read pointer on each transfer, finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_idx   <= '0;
      r_rem   <= '0;
      r_desc  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_desc <= descending;
            r_rem  <= w_cnt;
            r_idx  <= w_first_idx;
            // An empty unload skips straight to the completion cycle.
            r_state <= (w_cnt == '0) ? c_st_done : c_st_stream;
          end
        end
        c_st_stream: begin
          if (w_final_xfer) begin
            // Pointer is left in place on the last entry so it never
            // steps outside 0..cnt-1.
            r_rem   <= '0;
            r_state <= c_st_done;
          end else if (w_xfer) begin
            r_idx <= w_next_idx;
            r_rem <= r_rem - c_one_cnt;
          end
        end
        c_st_done: begin
          r_idx   <= '0;
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only, so an asynchronous
  // reset clears them at once and they hold steady under backpressure.
  always_comb begin
    out_valid = w_stream;
    out_data  = w_stream ? r_snap[r_idx] : '0;
    out_last  = w_stream && (r_rem == c_one_cnt);
    busy      = !w_idle;
    done      = (r_state == c_st_done);
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_unloader
//  Description : Directed self-checking bench for sort_unloader. Expected
//                entries are queued when an unload is launched and popped
//                as the DUT hands them over.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sort_unloader;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [DEPTH*DATA_W-1:0] sorted_in;
  logic [CNT_W-1:0]        count;
  logic                    descending;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t q_exp[$];
  int   checks   = 0;
  int   failures = 0;

  sort_unloader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sorted_in  (sorted_in),
    .count      (count),
    .descending (descending),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch an unload at the current negedge and queue the expected stream.
  task automatic do_start(input logic [DEPTH*DATA_W-1:0] vec, input int cnt, input logic desc);
    int c;
    int idx;
    exp_t e;
    start      = 1'b1;
    sorted_in  = vec;
    count      = CNT_W'(cnt);
    descending = desc;
    c = (cnt > DEPTH) ? DEPTH : cnt;
    for (int k = 0; k < c; k++) begin
      idx    = desc ? (c - 1 - k) : k;
      e.data = vec[idx*DATA_W +: DATA_W];
      e.last = (k == c - 1);
      q_exp.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drain the stream with a ready pattern (bit i used in cycle i+1, then 1).
  // exp_done > 0 fixes the cycle (after start) of the done pulse.
  // perturb > 0 scrambles inputs and pulses start in that cycle.
  task automatic drain(input logic [15:0] pat, input int pat_len, input int exp_done, input int perturb);
    int   it;
    int   last_xfer;
    bit   seen_done;
    logic rdy;
    exp_t e;
    it        = 1;
    last_xfer = -1;
    seen_done = 1'b0;
    while (!seen_done && it <= 40) begin
      if (it == perturb) begin
        start      = 1'b1;
        sorted_in  = {$urandom(), $urandom()};
        count      = CNT_W'($urandom_range(0, 15));
        descending = ~descending;
      end else if (it == perturb + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_valid_low", out_valid, 0);
        check("done_last_low", out_last, 0);
        check("done_busy_high", busy, 1);
        if (exp_done > 0) check("done_cycle", it, exp_done);
        if (last_xfer > 0) check("done_after_last", it, last_xfer + 1);
      end else if (out_valid) begin
        check("stream_busy", busy, 1);
        if (q_exp.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          e = q_exp[0];
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
      end else begin
        check("stream_valid", out_valid, 1);
      end
      rdy = (it <= pat_len) ? pat[it-1] : 1'b1;
      out_ready = rdy;
      if (!seen_done && out_valid && rdy) begin
        if (q_exp.size() > 0) void'(q_exp.pop_front());
        last_xfer = it;
      end
      @(negedge clk);
      it++;
    end
    start = 1'b0;
    check("drain_finished", seen_done, 1);
    check("queue_empty", q_exp.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_valid", out_valid, 0);
  endtask

  localparam logic [63:0] V1 = 64'hAA55110B0A050401;
  localparam logic [63:0] V2 = 64'h9999999999AA0504;
  localparam logic [63:0] V3 = 64'h7766554433221100;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    sorted_in  = '0;
    count      = '0;
    descending = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);

    // Ascending full chain, continuous ready
    do_start(V1, 8, 1'b0);
    drain(16'hFFFF, 16, 9, 0);

    // Descending, three entries
    do_start(V2, 3, 1'b1);
    drain(16'hFFFF, 16, 4, 0);

    // Backpressure: ready 1,0,0,1,0,1,1
    do_start(V1, 4, 1'b0);
    drain(16'h0069, 7, 8, 0);

    // Snapshot isolation, then a start in the idle cycle right after done
    do_start(V1, 8, 1'b1);
    drain(16'hFFFF, 16, 9, 3);
    do_start(V3, 5, 1'b0);
    drain(16'hFFFF, 16, 6, 0);

    // Empty unload and clamped count
    do_start(V1, 0, 1'b0);
    drain(16'hFFFF, 16, 1, 0);
    do_start(V1, 12, 1'b0);
    drain(16'hFFFF, 16, 9, 0);

    // Reset abort after the second transfer
    do_start(V1, 8, 1'b0);
    out_ready = 1'b1;
    check("abort_e0", out_data, 8'h01);
    @(negedge clk);
    check("abort_e1", out_data, 8'h04);
    @(negedge clk);
    check("abort_e2_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", out_data, 0);
    q_exp.delete();
    @(negedge clk);
    check("abort_no_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_abort_idle", busy, 0);
    do_start(V1, 8, 1'b0);
    drain(16'hFFFF, 16, 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
